// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for the parallel-in, serial-out serializer.
// The master side is the producer / downstream consumer; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             bit_en;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output din,
        output load_valid,
        output bit_en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  frame_start,
        input  frame_end,
        input  busy
    );

    modport slave (
        input  din,
        input  load_valid,
        input  bit_en,
        output load_ready,
        output sout,
        output sout_valid,
        output frame_start,
        output frame_end,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Words are shifted out one bit per enabled clock with frame-start/frame-end
// markers; a new word loaded during the last enabled bit follows with no gap.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    piso_serializer_if.slave     bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;

    logic w_lastBit;
    logic w_ready;
    logic w_accept;
    logic w_outBit;

    // Last bit of the current word is on the line; the next word may be taken
    // on the edge that retires it, which is what makes back-to-back streaming gapless.
    assign w_lastBit = (r_state == SHIFT) && (r_cnt == LAST);
    assign w_ready   = i_rst_n && ((r_state == IDLE) || (w_lastBit && bus.bit_en));
    assign w_accept  = bus.load_valid && w_ready;
    assign w_outBit  = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];

    // Single FSM: load on accept, shift on each enabled bit, drop to idle after the last bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_shreg <= bus.din;
            r_cnt   <= '0;
        end else if ((r_state == SHIFT) && bus.bit_en) begin
            if (r_cnt == LAST) begin
                r_state <= IDLE;
                r_shreg <= '0;
                r_cnt   <= '0;
            end else begin
                if (MSB_FIRST != 0) begin
                    r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                end else begin
                    r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                end
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.load_ready  = w_ready;
    assign bus.sout        = (r_state == SHIFT) ? w_outBit : 1'b0;
    assign bus.sout_valid  = (r_state == SHIFT);
    assign bus.busy        = (r_state == SHIFT);
    assign bus.frame_start = (r_state == SHIFT) && (r_cnt == '0);
    assign bus.frame_end   = w_lastBit;
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first and an LSB-first instance
// share the same stimulus and are compared against a word/bit-position model,
// hand-computed vector tables, and a serial-in parallel-out loopback chain.
module tb_piso_serializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         tValid;
    logic [W-1:0] tDin;
    logic         tEn;

    piso_serializer_if #(.WIDTH(W)) busM ();
    piso_serializer_if #(.WIDTH(W)) busL ();

    assign busM.load_valid = tValid;
    assign busM.din        = tDin;
    assign busM.bit_en     = tEn;
    assign busL.load_valid = tValid;
    assign busL.din        = tDin;
    assign busL.bit_en     = tEn;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dutMsb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (busM.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dutLsb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (busL.slave)
    );

    // Receive-side chain fed by the MSB-first serial line; chain[0] is the first stage.
    logic [W-1:0] chain = '0;
    always @(posedge clk) chain <= {chain[W-2:0], busM.sout};

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: the word in flight and which bit (in send order) is on the line.
    bit           mActive = 1'b0;
    logic [W-1:0] mWord   = '0;
    int           mPos    = 0;

    // Output snapshots taken at the falling edge: {ready, valid, start, end, sout, busy}.
    logic [5:0]   snapM;
    logic [5:0]   snapL;
    logic [W-1:0] snapChain;

    function automatic logic [5:0] modelOut(input bit msb);
        logic r, v, s, e, o;
        r = rst_n && (!mActive || ((mPos == W - 1) && tEn));
        v = mActive;
        s = mActive && (mPos == 0);
        e = mActive && (mPos == W - 1);
        o = mActive ? (msb ? mWord[W - 1 - mPos] : mWord[mPos]) : 1'b0;
        return {r, v, s, e, o, v};
    endfunction

    function automatic logic [5:0] packM();
        return {busM.load_ready, busM.sout_valid, busM.frame_start, busM.frame_end, busM.sout, busM.busy};
    endfunction

    function automatic logic [5:0] packL();
        return {busL.load_ready, busL.sout_valid, busL.frame_start, busL.frame_end, busL.sout, busL.busy};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic [5:0] expM;
        logic [5:0] expL;
        expM = modelOut(1'b1);
        expL = modelOut(1'b0);
        snapM = packM();
        snapL = packL();
        snapChain = chain;
        checkVal("model_msb", {26'd0, snapM}, {26'd0, expM});
        checkVal("model_lsb", {26'd0, snapL}, {26'd0, expL});
    endtask

    // Advance the model across one rising edge using the inputs that were present at it.
    task automatic modelStep();
        bit acc;
        acc = rst_n && tValid && (!mActive || ((mPos == W - 1) && tEn));
        if (!rst_n) begin
            mActive = 1'b0;
            mPos    = 0;
        end else if (acc) begin
            mActive = 1'b1;
            mWord   = tDin;
            mPos    = 0;
        end else if (mActive && tEn) begin
            if (mPos == W - 1) mActive = 1'b0;
            else mPos++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic e);
        tValid = v;
        tDin   = d;
        tEn    = e;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         e;
        logic [4:0]   expM;
        logic [4:0]   expL;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [3:0] stallM;
        logic [3:0] stallL;
        logic [W-1:0] word;

        // Expected {ready, valid, start, end, sout}: single word 1011, then A and 5 back-to-back.
        tbl[0]  = '{1'b1, 4'b1011, 1'b1, 5'b10000, 5'b10000};
        tbl[1]  = '{1'b0, 4'b0000, 1'b1, 5'b01101, 5'b01101};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 5'b01000, 5'b01001};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 5'b01001, 5'b01000};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 5'b11011, 5'b11011};
        tbl[5]  = '{1'b1, 4'hA,    1'b1, 5'b10000, 5'b10000};
        tbl[6]  = '{1'b1, 4'h5,    1'b1, 5'b01101, 5'b01100};
        tbl[7]  = '{1'b1, 4'h5,    1'b1, 5'b01000, 5'b01001};
        tbl[8]  = '{1'b1, 4'h5,    1'b1, 5'b01001, 5'b01000};
        tbl[9]  = '{1'b1, 4'h5,    1'b1, 5'b11010, 5'b11011};
        tbl[10] = '{1'b0, 4'h0,    1'b1, 5'b01100, 5'b01101};
        tbl[11] = '{1'b0, 4'h0,    1'b1, 5'b01001, 5'b01000};
        tbl[12] = '{1'b0, 4'h0,    1'b1, 5'b01000, 5'b01001};
        tbl[13] = '{1'b0, 4'h0,    1'b1, 5'b11011, 5'b11010};
        tbl[14] = '{1'b0, 4'h0,    1'b1, 5'b10000, 5'b10000};

        tValid = 1'b0;
        tDin   = '0;
        tEn    = 1'b0;

        // Power-on reset: everything low, including load_ready.
        #3;
        checkVal("reset_outputs", {26'd0, packM(), packL()} , 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkVal("after_reset", {26'd0, snapM}, {26'd0, 6'b100000});

        // Table-driven single-word and back-to-back vectors.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].e);
            checkVal($sformatf("tbl_msb_%0d", i), {27'd0, snapM[5:1]}, {27'd0, tbl[i].expM});
            checkVal($sformatf("tbl_lsb_%0d", i), {27'd0, snapL[5:1]}, {27'd0, tbl[i].expL});
        end

        // Stall: bit_en one cycle in three, word 1100 held on each bit until its enabled edge.
        applyStimulus(1'b1, 4'b1100, 1'b1);
        stallM = '0;
        stallL = '0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 4'b1100, (k % 3) == 2);
            if ((k % 3) == 2) begin
                stallM = {stallM[2:0], snapM[1]};
                stallL = {stallL[2:0], snapL[1]};
            end else begin
                checkVal("stall_ready_low", {31'd0, snapM[5]}, 32'd0);
            end
        end
        checkVal("stall_order_msb", {28'd0, stallM}, {28'd0, 4'b1100});
        checkVal("stall_order_lsb", {28'd0, stallL}, {28'd0, 4'b0011});
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkVal("stall_idle", {26'd0, snapM}, {26'd0, 6'b100000});

        // Loopback into the SIPO chain: the cycle after frame_end shows the sent word.
        for (int n = 0; n < 3; n++) begin
            word = (n == 0) ? 4'b1011 : W'($urandom);
            applyStimulus(1'b1, word, 1'b1);
            for (int k = 0; k < W; k++) applyStimulus(1'b0, 4'h0, 1'b1);
            applyStimulus(1'b0, 4'h0, 1'b1);
            checkVal("loopback_word", {28'd0, snapChain}, {28'd0, word});
        end

        // Reset asserted mid-word clears everything at once and discards the word.
        applyStimulus(1'b1, 4'b0110, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        checkVal("midword_reset", {20'd0, packM(), packL()}, 32'd0);
        mActive = 1'b0;
        mPos    = 0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'hF, 1'b1);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'h0, 1'b1);
        checkVal("release_reset", {26'd0, snapM}, {26'd0, 6'b100000});

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
